// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared types and constants for the sequential divider.
//   state_e        - controller states (IDLE, CALC, DONE)
//   DEFAULT_WIDTH  - default operand/result width
package seq_div_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_div_sub_bw.sv
// sub_bw: N-bit unsigned subtractor with borrow out.
// The divider instantiates exactly one of these.
//   a      in   minuend
//   b      in   subtrahend
//   diff   out  a - b (modulo 2^N)
//   borrow out  1 when b > a
module sub_bw #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/seq_div.sv
// seq_div: sequential unsigned restoring divider, start/done handshake.
// One quotient bit is resolved per clock using a single shared subtractor;
// restore vs. keep is only a multiplexer select on its result.
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   request, only honoured in IDLE
//   dividend     in   WIDTH-bit dividend, sampled with accepted start
//   divisor      in   WIDTH-bit divisor, sampled with accepted start
//   busy         out  high while iterating
//   done         out  one-cycle pulse, results valid
//   quotient     out  result, held until the next completion
//   remainder    out  result, held until the next completion
//   div_by_zero  out  last operation had a zero divisor
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one restoring iteration per clock, WIDTH clocks
// DONE  | results just registered, done pulse
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e           state_q;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] quot_q, rem_q;

  logic [WIDTH:0]   s_w, t_w;
  logic             borrow_w;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign s_w = {p_q[WIDTH-1:0], q_q[WIDTH-1]};

  sub_bw #(.N(WIDTH + 1)) u_sub (
    .a      (s_w),
    .b      ({1'b0, d_q}),
    .diff   (t_w),
    .borrow (borrow_w)
  );

  // Restoring step: on borrow keep the shifted value, else take the difference.
  always_comb begin
    p_d = borrow_w ? s_w : t_w;
    q_d = {q_q[WIDTH-2:0], ~borrow_w};
  end

  // The partial remainder never exceeds the divisor, so its MSB is always
  // zero after a non-borrow step and is not needed downstream.
  logic unused_p_msb;
  assign unused_p_msb = p_q[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              quot_q  <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              q_q     <= dividend;
              p_q     <= '0;
              d_q     <= divisor;
              cnt_q   <= CNT_INIT;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          p_q   <= p_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == '0) begin
            quot_q  <= q_d;
            rem_q   <= p_d[WIDTH-1:0];
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
